// File: rtl/npc_bpred.sv
// Next-PC unit with a direct-mapped BTB and 2-bit direction counters.
// Holds the fetch PC, predicts the next fetch address in the same cycle,
// and redirects fetch when EX resolves a control transfer differently
// from what was predicted at fetch.
module npc_bpred #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     BTB_DEPTH = 16,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic            ex_is_jump,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc4,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  output logic            redirect
);

  localparam int unsigned     IDX  = $clog2(BTB_DEPTH);
  localparam int unsigned     TAGW = XLEN - IDX - 2;
  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  logic [XLEN-1:0] pc_q, pc_d;

  logic            valid_q  [BTB_DEPTH];
  logic            valid_d  [BTB_DEPTH];
  logic [TAGW-1:0] tag_q    [BTB_DEPTH];
  logic [TAGW-1:0] tag_d    [BTB_DEPTH];
  logic [XLEN-1:0] target_q [BTB_DEPTH];
  logic [XLEN-1:0] target_d [BTB_DEPTH];
  logic            jump_q   [BTB_DEPTH];
  logic            jump_d   [BTB_DEPTH];
  logic [1:0]      ctr_q    [BTB_DEPTH];
  logic [1:0]      ctr_d    [BTB_DEPTH];

  logic [IDX-1:0]  f_idx, e_idx;
  logic [TAGW-1:0] f_tag, e_tag;
  logic            f_hit, e_hit;
  logic [XLEN-1:0] ex_pc4;
  logic [XLEN-1:0] actual_next, pred_next;
  logic            redirect_w;

  assign f_idx = pc_q[IDX+1:2];
  assign f_tag = pc_q[XLEN-1:IDX+2];
  assign e_idx = ex_pc[IDX+1:2];
  assign e_tag = ex_pc[XLEN-1:IDX+2];

  // Fetch-side lookup always sees the pre-update BTB contents.
  assign f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign e_hit       = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
  assign pred_taken  = f_hit && (jump_q[f_idx] || ctr_q[f_idx][1]);
  assign pred_target = target_q[f_idx];

  assign pc     = pc_q;
  assign pc4    = pc_q + FOUR;
  assign ex_pc4 = ex_pc + FOUR;

  // Compare where EX actually went against where fetch assumed it would go.
  always_comb begin
    actual_next = ex_pc4;
    if (ex_is_jump || (ex_is_branch && ex_taken)) actual_next = ex_target;
    pred_next = ex_pred_taken ? ex_pred_target : ex_pc4;
  end

  assign redirect_w = ex_valid && (actual_next != pred_next);
  assign redirect   = redirect_w;

  // Next fetch PC: a mispredict wins even over a stall.
  always_comb begin
    pc_d = pc_q + FOUR;
    if (redirect_w)      pc_d = actual_next;
    else if (stall)      pc_d = pc_q;
    else if (pred_taken) pc_d = pred_target;
  end

  // BTB training from resolved branches/jumps; not gated by stall.
  always_comb begin
    for (int i = 0; i < int'(BTB_DEPTH); i++) begin
      valid_d[i]  = valid_q[i];
      tag_d[i]    = tag_q[i];
      target_d[i] = target_q[i];
      jump_d[i]   = jump_q[i];
      ctr_d[i]    = ctr_q[i];
    end
    if (ex_valid && (ex_is_branch || ex_is_jump)) begin
      if (e_hit) begin
        target_d[e_idx] = ex_target;
        jump_d[e_idx]   = ex_is_jump;
        if (ex_is_branch) begin
          if (ex_taken && (ctr_q[e_idx] != 2'b11))
            ctr_d[e_idx] = ctr_q[e_idx] + 2'b01;
          else if (!ex_taken && (ctr_q[e_idx] != 2'b00))
            ctr_d[e_idx] = ctr_q[e_idx] - 2'b01;
        end
      end else if (ex_is_jump || ex_taken) begin
        // Not-taken branches that miss are not worth a BTB entry.
        valid_d[e_idx]  = 1'b1;
        tag_d[e_idx]    = e_tag;
        target_d[e_idx] = ex_target;
        jump_d[e_idx]   = ex_is_jump;
        ctr_d[e_idx]    = 2'b10;
      end
    end
  end

  // State registers; counters reset weakly not-taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
      for (int i = 0; i < int'(BTB_DEPTH); i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        jump_q[i]   <= 1'b0;
        ctr_q[i]    <= 2'b01;
      end
    end else begin
      pc_q <= pc_d;
      for (int i = 0; i < int'(BTB_DEPTH); i++) begin
        valid_q[i]  <= valid_d[i];
        tag_q[i]    <= tag_d[i];
        target_q[i] <= target_d[i];
        jump_q[i]   <= jump_d[i];
        ctr_q[i]    <= ctr_d[i];
      end
    end
  end

endmodule
